// File: rtl/buf_pkg.sv
// Shared types and constants for the buffer receive path.
// Contains the filter state enum, the counter-width helper and the synchroniser depth.
package buf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } buf_rx_state_t;

    localparam int BUF_SYNC_STAGES = 2;

    // Width needed to hold values 0..stable_cycles.
    function automatic int buf_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/buf_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
// It is reusable for any asynchronous input. The flops take RESET_VAL while reset is held.
module buf_sync2
    import buf_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic [BUF_SYNC_STAGES-1:0] stages;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stages <= {BUF_SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[BUF_SYNC_STAGES-2:0], D};
        end
    end

    assign Q = stages[BUF_SYNC_STAGES-1];

endmodule

// File: rtl/buf_rx_filter.sv
// Glitch filter for an asynchronous input line.
// The line is synchronised first. Y then follows it only after the new level
// has held for STABLE_CYCLES consecutive clocks.
// Optional RISE/FALL edge pulses are built only when BUF_RX_EDGE_EN is defined.
// Otherwise both outputs are tied to 0.
//
// state | meaning
// IDLE  | synchronised input equals Y, counter cleared
// QUAL  | input differs from Y, counting consecutive stable cycles
module buf_rx_filter
    import buf_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic A,
    output logic Y,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam int            CW       = buf_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_param
        $error("buf_rx_filter: STABLE_CYCLES must be in 1..255");
    end

    logic          s2;
    buf_rx_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          y_q, y_nxt;

    buf_sync2 #(.RESET_VAL(RESET_VAL)) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (A),
        .Q     (s2)
    );

    // State, qualification counter and filtered output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            y_q   <= RESET_VAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y_q   <= y_nxt;
        end
    end

    // Next-state logic. Any return to the old level throws away the accumulated count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y_q;
        case (state)
            IDLE: begin
                if (s2 != y_q) begin
                    if (STABLE_CYCLES == 1) begin
                        y_nxt = s2;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = QUAL;
                    end
                end
            end
            QUAL: begin
                if (s2 == y_q) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    y_nxt     = s2;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef BUF_RX_EDGE_EN
    logic rise_q, fall_q;

    // Edge pulses are registered together with Y, so they line up with the new level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= ~y_q & y_nxt;
            fall_q <= y_q & ~y_nxt;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

    assign Y    = y_q;
    assign BUSY = (state == QUAL);

endmodule

// File: tb/tb_buf_rx_filter.sv
// Self-checking bench for buf_rx_filter.
// It runs two instances side by side: STABLE_CYCLES=4 and STABLE_CYCLES=1.
// A run-length model is checked against both instances on every falling edge.
// Directed literal checks pin the model to the expected latencies.
module tb_buf_rx_filter;

`ifdef BUF_RX_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a4 = 1'b0, a1 = 1'b0;
    logic y4, rise4, fall4, busy4;
    logic y1, rise1, fall1, busy1;

    int n_cmp = 0;
    int n_bad = 0;
    bit tog_en = 1'b0;

    always #5 clk = ~clk;

    buf_rx_filter #(.STABLE_CYCLES(4), .RESET_VAL(1'b0)) dut4 (
        .CLK(clk), .RST_N(rst_n), .A(a4), .Y(y4), .RISE(rise4), .FALL(fall4), .BUSY(busy4)
    );

    buf_rx_filter #(.STABLE_CYCLES(1), .RESET_VAL(1'b0)) dut1 (
        .CLK(clk), .RST_N(rst_n), .A(a1), .Y(y1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
    );

    // Model, index 0 for the STABLE_CYCLES=4 instance and 1 for STABLE_CYCLES=1.
    // Y flips once the synchronised line has disagreed with it on `stable` consecutive edges.
    int   stable [2] = '{4, 1};
    logic m_p1 [2], m_p2 [2], m_y [2], m_rise [2], m_fall [2], m_busy [2];
    int   run [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_y[i] = 1'b0;
                m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0; run[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic old_y;
                old_y = m_y[i];
                run[i] = (m_p2[i] != m_y[i]) ? run[i] + 1 : 0;
                if (run[i] >= stable[i]) begin
                    m_y[i] = m_p2[i];
                    run[i] = 0;
                end
                m_busy[i] = (run[i] > 0);
                m_rise[i] = EDGE_EN && !old_y && m_y[i];
                m_fall[i] = EDGE_EN && old_y && !m_y[i];
                m_p2[i]   = m_p1[i];
                m_p1[i]   = (i == 0) ? a4 : a1;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        check("y4",    y4,    m_y[0]);
        check("busy4", busy4, m_busy[0]);
        check("rise4", rise4, m_rise[0]);
        check("fall4", fall4, m_fall[0]);
        check("y1",    y1,    m_y[1]);
        check("busy1", busy1, m_busy[1]);
        check("rise1", rise1, m_rise[1]);
        check("fall1", fall1, m_fall[1]);
    end

    // Toggle the STABLE_CYCLES=1 line every 4 cycles once enabled.
    initial begin
        wait (tog_en);
        forever begin
            repeat (4) @(negedge clk);
            a1 = ~a1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with A4 already high.
        a4 = 1'b1;
        step(3);
        check("rst_y4", y4, 1'b0);
        check("rst_busy4", busy4, 1'b0);
        check("rst_rise4", rise4, 1'b0);
        check("rst_fall4", fall4, 1'b0);
        rst_n = 1'b1;
        a1 = 1'b1;
        step(2);                       // edges 0,1
        check("lat1_before", y1, 1'b0);
        step(1);                       // edge 2
        check("lat1_after", y1, 1'b1);
        check("busy4_e2", busy4, 1'b1);
        step(2);                       // edges 3,4
        check("rel_y4_e4", y4, 1'b0);
        step(1);                       // edge 5
        check("rel_y4_e5", y4, 1'b1);
        check("rel_rise4", rise4, EDGE_EN);
        step(1);
        check("rel_rise4_off", rise4, 1'b0);
        check("rel_busy4_off", busy4, 1'b0);
        tog_en = 1'b1;

        // Clean fall, then clean rise.
        a4 = 1'b0;
        step(6);
        check("fall_y4", y4, 1'b0);
        check("fall_pulse", fall4, EDGE_EN);
        step(4);
        a4 = 1'b1;
        step(2);
        check("rise_busy_e1", busy4, 1'b0);
        step(1);
        check("rise_busy_e2", busy4, 1'b1);
        step(2);
        check("rise_y_e4", y4, 1'b0);
        step(1);
        check("rise_y_e5", y4, 1'b1);
        check("rise_pulse", rise4, EDGE_EN);
        check("rise_nofall", fall4, 1'b0);
        step(6);

        // Three-cycle pulse while Y is high is rejected.
        a4 = 1'b0;
        step(3);
        a4 = 1'b1;
        step(10);
        check("glitch_y4", y4, 1'b1);
        check("glitch_busy4", busy4, 1'b0);

        // Fall back to 0, then a rise with a one-cycle dip mid-qualification.
        a4 = 1'b0;
        step(8);
        a4 = 1'b1;
        step(3);
        a4 = 1'b0;
        step(1);
        a4 = 1'b1;
        step(5);
        check("dip_y4_early", y4, 1'b0);
        step(1);
        check("dip_y4_rise", y4, 1'b1);
        step(4);

        // Reset asserted mid-qualification aborts it.
        a4 = 1'b0;
        step(3);
        check("midq_busy", busy4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midq_y4", y4, 1'b0);
        check("midq_busy4", busy4, 1'b0);
        check("midq_fall4", fall4, 1'b0);
        step(2);
        check("midq_nofall", fall4, 1'b0);
        rst_n = 1'b1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
